s2p_rx: RTL and testbench
=========================

S2P_RX -- requirements
Module: s2p_rx

Interface
REQ-001 Parameter WIDTH, default 8, payload bits per frame.
REQ-002 Parameter MSB_FIRST, default 1, payload bit order on the line (1 = MSB first, 0 = LSB first).
REQ-003 srClock  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 dataIn  input  1  serial line; idle high; synchronous to srClock.
REQ-006 data  output  WIDTH  last correctly framed payload.
REQ-007 valid  output  1  one-cycle pulse: data was just updated.
REQ-008 frameErr  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 busy  output  1  high while a frame is in progress (DATA or STOP state).

Function
REQ-010 The line format SHALL be: one start bit (0), WIDTH payload bits, one stop bit (1), one bit per srClock cycle.
REQ-011 The block SHALL implement states IDLE, DATA and STOP.
REQ-012 IDLE: dataIn sampled 0 -> DATA with bit counter 0; dataIn sampled 1 -> remain IDLE, no output change.
REQ-013 DATA: each cycle SHALL shift dataIn into the shift register per MSB_FIRST and increment the counter.
REQ-014 DATA -> STOP SHALL occur on the edge that samples payload bit WIDTH-1.
REQ-015 STOP with dataIn=1: data <= shift register and valid=1 for exactly one cycle after that edge; next state IDLE.
REQ-016 STOP with dataIn=0: frameErr=1 for exactly one cycle; data unchanged; valid stays 0; next state IDLE.
REQ-017 Latency: valid SHALL be high in the cycle immediately after the stop-bit edge, i.e. WIDTH+2 edges after the start-bit edge.
REQ-018 valid and frameErr SHALL never be high in the same cycle.
REQ-019 A start bit in the cycle directly after STOP SHALL be accepted (back-to-back frames, 10-cycle period for WIDTH=8).
REQ-020 Start-bit edges SHALL NOT be glitch-filtered or oversampled; dataIn is taken as already synchronised.
REQ-021 The bit counter SHALL be $clog2(WIDTH)+1 bits wide; it SHALL NOT wrap within a frame.
REQ-022 busy SHALL be 1 in DATA and STOP, 0 in IDLE.
REQ-023 data SHALL hold its value between frames and across framing errors.

Reset
REQ-024 When rst=1 at a rising edge: state=IDLE, counter=0, shift register=0, data=0, valid=0, frameErr=0, busy=0.
REQ-025 rst SHALL take priority over all other inputs in the same cycle.
REQ-026 Reset mid-frame SHALL discard the partial frame; no valid or frameErr pulse results.
REQ-027 The first sample after rst deasserts SHALL be treated as in IDLE.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE/DATA/STOP), START_BIT=0, STOP_BIT=1 and the default WIDTH, for reuse by the transmitter.
REQ-029 One sub-module, s2p_shifter (WIDTH-bit shift-in register with enable and direction parameter), SHALL be instantiated; the FSM and counter stay in s2p_rx.
REQ-030 Estimated implementation size: 120-250 lines of RTL.

Verification
REQ-031 Reset, then idle high 5 cycles, then frame 0 10101011 1 (MSB first) -> data=8'hAB, valid for one cycle, busy high for 9 cycles.
REQ-032 Frame 0x0F followed immediately by frame 0xF0 with no idle gap -> two valid pulses 10 cycles apart; data=8'h0F, then 8'hF0.
REQ-033 Frame 0x55 with stop bit 0 -> frameErr for one cycle; data keeps the prior 8'hAB; no valid pulse.
REQ-034 rst asserted during payload bit 4 -> all outputs 0 the next cycle; no pulse; a following clean frame 0x3C -> data=8'h3C.
REQ-035 MSB_FIRST=0 with line bits 1,1,0,1,0,1,0,1 -> data=8'hAB.
REQ-036 dataIn held high for 20 cycles -> busy, valid and frameErr all stay 0.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared definitions for the serial-to-parallel link: state encoding, line levels
// and default payload width, reused by the matching transmitter.
package s2p_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StStop
    } s2p_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/s2p_shifter.sv
// WIDTH-bit shift-in register with enable; MsbFirst selects which end new bits enter.
module s2p_shifter #(
    parameter int unsigned Width    = 8,
    parameter bit          MsbFirst = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            // MSB-first: earliest bit ends up at the top; LSB-first: at the bottom.
            if (MsbFirst) begin
                q_d = {q_q[Width-2:0], bit_i};
            end else begin
                q_d = {bit_i, q_q[Width-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/s2p_rx.sv
// Serial frame receiver: start bit, WIDTH payload bits, stop bit, one bit per clock.
// Publishes the payload with a one-cycle valid pulse, or flags a bad stop bit.
module s2p_rx
    import s2p_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             srClock,
    input  logic             rst,
    input  logic             dataIn,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frameErr,
    output logic             busy
);

    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    s2p_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             shift_en;
    logic [WIDTH-1:0] shift_q;

    s2p_shifter #(
        .Width   (WIDTH),
        .MsbFirst(MSB_FIRST)
    ) u_shifter (
        .clk_i(srClock),
        .rst_i(rst),
        .en_i (shift_en),
        .bit_i(dataIn),
        .q_o  (shift_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dataIn == START_BIT) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // Return to idle either way so a start bit next cycle is accepted.
                state_d = StIdle;
                if (dataIn == STOP_BIT) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    ferr_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge srClock) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign frameErr = ferr_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_s2p_rx.sv
// Bench for s2p_rx: directed scenarios plus random line traffic, both bit orders,
// checked every cycle against a frame-level reference model.
module tb_s2p_rx;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         din;
    logic [W-1:0] data_m, data_l;
    logic         valid_m, valid_l, ferr_m, ferr_l, busy_m, busy_l;

    s2p_rx #(
        .WIDTH    (W),
        .MSB_FIRST(1'b1)
    ) u_dut_msb (
        .srClock (clk),
        .rst     (rst),
        .dataIn  (din),
        .data    (data_m),
        .valid   (valid_m),
        .frameErr(ferr_m),
        .busy    (busy_m)
    );

    s2p_rx #(
        .WIDTH    (W),
        .MSB_FIRST(1'b0)
    ) u_dut_lsb (
        .srClock (clk),
        .rst     (rst),
        .dataIn  (din),
        .data    (data_l),
        .valid   (valid_l),
        .frameErr(ferr_l),
        .busy    (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pos = -1 idle, 0..W-1 next payload index, W awaiting stop bit.
    int pos = -1;
    int b[W];
    int exp_data_m = 0, exp_data_l = 0;
    int exp_valid = 0, exp_ferr = 0, exp_busy = 0;

    int cyc = 0;
    int valid_cnt = 0, ferr_cnt = 0, busy_cnt = 0;
    int vcyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int msb_value();
        int v = 0;
        for (int i = 0; i < W; i++) v = v * 2 + b[i];
        return v;
    endfunction

    function automatic int lsb_value();
        int v = 0;
        for (int i = 0; i < W; i++) v = v + b[i] * (1 << i);
        return v;
    endfunction

    // Drive one line bit, advance the model, then compare both DUTs after the edge.
    task automatic step(input logic d, input logic r);
        rst = r;
        din = d;
        exp_valid = 0;
        exp_ferr  = 0;
        if (r) begin
            pos = -1;
            exp_data_m = 0;
            exp_data_l = 0;
        end else if (pos < 0) begin
            if (d == 1'b0) pos = 0;
        end else if (pos < W) begin
            b[pos] = int'(d);
            pos++;
        end else begin
            if (d) begin
                exp_data_m = msb_value();
                exp_data_l = lsb_value();
                exp_valid  = 1;
            end else begin
                exp_ferr = 1;
            end
            pos = -1;
        end
        exp_busy = (pos >= 0) ? 1 : 0;
        @(posedge clk);
        #1;
        cyc++;
        check_eq("data_msb", 32'(data_m), 32'(exp_data_m));
        check_eq("data_lsb", 32'(data_l), 32'(exp_data_l));
        check_eq("valid_msb", 32'(valid_m), 32'(exp_valid));
        check_eq("valid_lsb", 32'(valid_l), 32'(exp_valid));
        check_eq("ferr_msb", 32'(ferr_m), 32'(exp_ferr));
        check_eq("ferr_lsb", 32'(ferr_l), 32'(exp_ferr));
        check_eq("busy_msb", 32'(busy_m), 32'(exp_busy));
        check_eq("busy_lsb", 32'(busy_l), 32'(exp_busy));
        check_eq("valid_ferr_excl", 32'(valid_m & ferr_m), 32'(0));
        if (valid_m) begin
            valid_cnt++;
            vcyc.push_back(cyc);
        end
        if (ferr_m) ferr_cnt++;
        if (busy_m) busy_cnt++;
    endtask

    task automatic send_frame(input logic [W-1:0] v, input logic stop);
        step(1'b0, 1'b0);
        for (int i = W - 1; i >= 0; i--) step(v[i], 1'b0);
        step(stop, 1'b0);
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        ferr_cnt  = 0;
        busy_cnt  = 0;
        vcyc.delete();
    endtask

    initial begin
        logic [W-1:0] pat;
        rst = 1'b1;
        din = 1'b1;

        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check_eq("rst_data", 32'(data_m), 32'(0));
        check_eq("rst_busy", 32'(busy_m), 32'(0));

        // Clean frame 0xAB after idle.
        repeat (5) step(1'b1, 1'b0);
        clear_counts();
        send_frame(8'hAB, 1'b1);
        step(1'b1, 1'b0);
        check_eq("ab_data", 32'(data_m), 32'h0000_00AB);
        check_eq("ab_valid_pulses", 32'(valid_cnt), 32'(1));
        check_eq("ab_busy_cycles", 32'(busy_cnt), 32'(9));

        // Bad stop bit: data retained, single error pulse.
        clear_counts();
        send_frame(8'h55, 1'b0);
        step(1'b1, 1'b0);
        check_eq("ferr_pulses", 32'(ferr_cnt), 32'(1));
        check_eq("ferr_no_valid", 32'(valid_cnt), 32'(0));
        check_eq("ferr_data_kept", 32'(data_m), 32'h0000_00AB);

        // Back-to-back frames with no idle gap.
        clear_counts();
        send_frame(8'h0F, 1'b1);
        check_eq("b2b_first", 32'(data_m), 32'h0000_000F);
        send_frame(8'hF0, 1'b1);
        check_eq("b2b_second", 32'(data_m), 32'h0000_00F0);
        check_eq("b2b_pulses", 32'(vcyc.size()), 32'(2));
        if (vcyc.size() == 2) check_eq("b2b_spacing", 32'(vcyc[1] - vcyc[0]), 32'(10));

        // Reset during payload bit 4, then a clean 0x3C.
        clear_counts();
        pat = 8'h3C;
        step(1'b0, 1'b0);
        for (int i = W - 1; i > 3; i--) step(pat[i], 1'b0);
        step(pat[3], 1'b1);
        check_eq("midrst_data", 32'(data_m), 32'(0));
        check_eq("midrst_busy", 32'(busy_m), 32'(0));
        step(1'b1, 1'b0);
        check_eq("midrst_no_pulse", 32'(valid_cnt + ferr_cnt), 32'(0));
        send_frame(8'h3C, 1'b1);
        check_eq("after_rst_data", 32'(data_m), 32'h0000_003C);

        // Line bits 1,1,0,1,0,1,0,1 read LSB-first give 0xAB.
        send_frame(8'hD5, 1'b1);
        check_eq("lsb_first_data", 32'(data_l), 32'h0000_00AB);

        // Long idle: nothing happens.
        clear_counts();
        repeat (20) step(1'b1, 1'b0);
        check_eq("idle_quiet", 32'(valid_cnt + ferr_cnt + busy_cnt), 32'(0));

        // Random frames with occasional bad stop bits and idle gaps.
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 3)) step(1'b1, 1'b0);
            send_frame(W'($urandom), ($urandom_range(0, 5) != 0));
        end

        // Fully random line with sporadic resets.
        for (int k = 0; k < 300; k++) begin
            step(logic'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
